mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port alu_result_mem_in, input, 32, byte address from the EX/MEM register.
REQ-004 SHALL have port read_data2_mem_in, input, 32, store data from the EX/MEM register.
REQ-005 SHALL have port mem_write_mem_in, input, 3, with [2] as store enable and [1:0] as size: 00 byte, 01 half, 10 word.
REQ-006 SHALL have port mem_read_mem_in, input, 4, with [3] as load enable and [2:0] as funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 SHALL have port dmem_req, output, 1, data memory request.
REQ-008 SHALL have port dmem_we, output, 1, 1 = write.
REQ-009 SHALL have port dmem_addr, output, 32, word-aligned address with [1:0] = 00.
REQ-010 SHALL have port dmem_wdata, output, 32, lane-replicated store data.
REQ-011 SHALL have port dmem_wstrb, output, 4, byte write strobes.
REQ-012 SHALL have port dmem_ack, input, 1, one-cycle completion pulse from memory.
REQ-013 SHALL have port dmem_rdata, input, 32, read word, valid with dmem_ack.
REQ-014 SHALL have port load_data_out, output, 32, extended load result for MEM/WB.
REQ-015 SHALL have port busywait, output, 1, pipeline stall request.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, and DONE.
REQ-017 SHALL treat an access as pending when mem_write_mem_in[2] or mem_read_mem_in[3] is set in IDLE; if both are set, the store SHALL win and the load SHALL be ignored.
REQ-018 SHALL, in IDLE with an access pending, assert busywait combinationally, latch address/data/control, and transition to REQ.
REQ-019 SHALL, in REQ, hold dmem_req=1 and hold dmem_we/addr/wdata/wstrb stable until dmem_ack, with busywait=1 throughout.
REQ-020 SHALL, in REQ with dmem_ack=1, register extended dmem_rdata into load_data_out for loads and transition to DONE; dmem_ack outside REQ SHALL be ignored.
REQ-021 SHALL, in DONE, drive busywait=0 for exactly one cycle, deassert dmem_req, and return to IDLE; a new access SHALL NOT be accepted in DONE.
REQ-022 SHALL, with ack in the first REQ cycle, give a minimum latency of 2 stall cycles per access; there SHALL be no upper bound on wait.
REQ-023 SHALL produce byte stores with wdata = {4{byte}} and wstrb = 0001<<addr[1:0].
REQ-024 SHALL produce halfword stores with wdata = {2{half}} and wstrb = 0011<<{addr[1],1'b0}.
REQ-025 SHALL produce word stores with wstrb = 1111.
REQ-026 SHALL select the load lane by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass through.
REQ-027 SHALL hold load_data_out until the next load completes; stores SHALL NOT modify it.
REQ-028 SHALL, with no access pending in IDLE, keep busywait=0 and dmem_req=0.

Reset
REQ-029 SHALL, with rst=1, force state to IDLE and drive dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, load_data_out=0, and busywait=0 on the next edge.
REQ-030 SHALL, on reset mid-REQ, abandon the access, drop dmem_req the following cycle, and ignore any late ack.

Configuration
REQ-031 SHALL, with macro MEM_MISALIGN_TRAP_EN defined, add output misalign_fault (1 bit) and assert it for one cycle in IDLE for a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access, with no request issued and busywait=0.
REQ-032 SHALL, with MEM_MISALIGN_TRAP_EN undefined, omit the port and force misaligned addresses to size alignment (half: addr[0]=0; word: addr[1:0]=0) before issue.

Verification
REQ-033 SHALL cover SW addr=0x104, data=0xDEADBEEF, ack after 3 REQ cycles -> dmem_addr=0x104, wstrb=1111, busywait high for 4 cycles, then DONE for 1 cycle.
REQ-034 SHALL cover SB addr=0x203, data=0x000000A5 -> wdata=0xA5A5A5A5, wstrb=1000.
REQ-035 SHALL cover LB addr=0x301, rdata=0x0000F000 -> load_data_out=0xFFFFFFF0; LBU at the same address -> 0x000000F0.
REQ-036 SHALL cover LH addr=0x402, rdata=0x80010000 -> 0xFFFF8001, with ack in the first REQ cycle giving exactly 2 busywait cycles.
REQ-037 SHALL cover rst during REQ -> next cycle IDLE with dmem_req=0, and an ack one cycle later leaves load_data_out=0.
REQ-038 SHALL cover LW addr=0x502 -> with MEM_MISALIGN_TRAP_EN, misalign_fault=1 and no dmem_req; without it, dmem_addr=0x500 is issued.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access unit: issues load/store requests, stalls the pipeline until ack, lane-aligns data.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign_fault instead of being aligned.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_mem_in,
    input  logic [31:0] read_data2_mem_in,
    input  logic [2:0]  mem_write_mem_in,
    input  logic [3:0]  mem_read_mem_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        busywait,
    output logic        misalign_fault
`else
    output logic        busywait
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_load_data;

    logic        w_is_store;
    logic        w_pending;
    logic        w_accept;
    logic [1:0]  w_size;
    logic [31:0] w_addr_al;

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   f_store_data = {4{data[7:0]}};
            2'b01:   f_store_data = {2{data[15:0]}};
            default: f_store_data = data;
        endcase
    endfunction

    function automatic logic [3:0] f_store_strb(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   f_store_strb = 4'b0001 << lane;
            2'b01:   f_store_strb = lane[1] ? 4'b1100 : 4'b0011;
            default: f_store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extend(input logic [2:0] funct3, input logic [1:0] lane,
                                                  input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  f_load_extend = {{24{b[7]}}, b};
            3'b001:  f_load_extend = {{16{h[15]}}, h};
            3'b100:  f_load_extend = {24'b0, b};
            3'b101:  f_load_extend = {16'b0, h};
            default: f_load_extend = rdata;
        endcase
    endfunction

    // Store takes priority when both enables are set; size of a load comes from funct3[1:0].
    assign w_is_store = mem_write_mem_in[2];
    assign w_pending  = mem_write_mem_in[2] | mem_read_mem_in[3];
    assign w_size     = w_is_store ? mem_write_mem_in[1:0] : mem_read_mem_in[1:0];

    always_comb begin
        w_addr_al = alu_result_mem_in;
        if (w_size == 2'b01)
            w_addr_al[0] = 1'b0;
        else if (w_size[1])
            w_addr_al[1:0] = 2'b00;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((w_size == 2'b01) && alu_result_mem_in[0]) ||
                          (w_size[1] && (alu_result_mem_in[1:0] != 2'b00));
    assign w_accept     = w_pending && !w_misaligned;
`else
    assign w_accept     = w_pending;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_REQ;
            S_REQ:   if (dmem_ack) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busywait       = 1'b0;
        dmem_req       = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_fault = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                busywait = w_accept;
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_fault = w_pending && w_misaligned;
`endif
            end
            S_REQ: begin
                busywait = 1'b1;
                dmem_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Request fields are captured once in IDLE so they stay stable for the whole REQ wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= 32'b0;
            r_wdata     <= 32'b0;
            r_wstrb     <= 4'b0;
            r_is_load   <= 1'b0;
            r_funct3    <= 3'b0;
            r_lane      <= 2'b0;
            r_load_data <= 32'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_we      <= w_is_store;
                r_addr    <= {w_addr_al[31:2], 2'b00};
                r_wdata   <= w_is_store ? f_store_data(w_size, read_data2_mem_in) : 32'b0;
                r_wstrb   <= w_is_store ? f_store_strb(w_size, w_addr_al[1:0]) : 4'b0;
                r_is_load <= !w_is_store;
                r_funct3  <= mem_read_mem_in[2:0];
                r_lane    <= w_addr_al[1:0];
            end
            if (r_state == S_REQ && dmem_ack && r_is_load)
                r_load_data <= f_load_extend(r_funct3, r_lane, dmem_rdata);
        end
    end

    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign dmem_wstrb    = r_wstrb;
    assign load_data_out = r_load_data;

endmodule
